sh7034_ext_slave: RTL
=====================

// Module: sh7034_ext_slave
// PURPOSE
// - External-bus responder: the device end of the SH7034 external bus (CS_N/RD_N/WRL_N/WRH_N/WAIT_N).
// - Sits on board side of the CPU pins, one instance per CS area.
// - Converts strobed accesses into a REQ/ACK request to a 16-bit backend memory/register port.
// - Stretches the bus cycle with WAIT_N until the backend answers or a timeout expires.
// PARAMETERS
// BUS16     1    1: 16-bit device (both lanes); 0: 8-bit device on DI/DO[7:0]
// MIN_WAIT  1    minimum CE_R ticks WAIT_N held low per access (0..7)
// TIMEOUT   255  CE_R ticks waiting for MEM_ACK before forced completion (1..255)
// PORTS
// CLK      in   1   system clock
// RST      in   1   synchronous reset, active high
// CE_R     in   1   rising-phase clock enable; all bus inputs sampled and WAIT_N/DO updated here
// CE_F     in   1   falling-phase clock enable (master strobe/sample phase; unused internally beyond lint)
// A        in   24  external address
// DI       in   16  write data from CPU pins
// DO       out  16  read data to CPU pins
// DO_OE    out  1   DO drive enable
// CS_N     in   1   this area's chip select, active low
// RD_N     in   1   read strobe, active low
// WRL_N    in   1   low-byte write strobe, active low
// WRH_N    in   1   high-byte write strobe, active low
// WAIT_N   out  1   wait request to CPU, active low
// MEM_A    out  24  backend byte address
// MEM_DO   out  16  backend write data
// MEM_DI   in   16  backend read data
// MEM_BE   out  2   backend byte enables {hi,lo}
// MEM_WE   out  1   backend write
// MEM_REQ  out  1   backend request, held until MEM_ACK
// MEM_ACK  in   1   backend done (1-cycle pulse, any CLK)
// ERR      out  1   sticky timeout flag
// ERR_CLR  in   1   clears ERR
// BEHAVIOUR
// - Reset: DO=0, DO_OE=0, WAIT_N=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_A=0, MEM_DO=0, ERR=0, state IDLE.
// - Reset mid-access: same values on next CLK; the pending MEM_REQ is dropped and a late MEM_ACK is ignored.
// - STROBE = ~CS_N & (~RD_N | ~WRL_N | ~WRH_N), sampled only on CE_R.
// - States (transitions on CE_R unless noted):
//   - IDLE: on STROBE, latch A/DI/strobes into MEM_*, set MEM_REQ=1, WAIT_N=0, clear counters -> ACC.
//   - ACC: MEM_ACK seen (any CLK) latches MEM_DI and drops MEM_REQ, sets "done".
//     - When done && wait count >= MIN_WAIT: WAIT_N=1, DO_OE=~RD_N -> HOLD.
//     - If timeout count reaches TIMEOUT first: MEM_REQ=0, ERR=1, read data forced 16'hFFFF, WAIT_N=1 -> HOLD.
//   - HOLD: DO stable; when RD_N & WRL_N & WRH_N all high (CS_N may stay low) -> DO_OE=0 -> IDLE.
//     - A new strobe needs a return to IDLE first; back-to-back accesses under held CS_N are supported.
// - Latency: strobe asserted at master CE_F -> WAIT_N low by the following CE_R, before the master's T2 sample edge.
//   - Minimum one wait state per access, even with MIN_WAIT=0.
// - BUS16=1 mapping:
//   - MEM_BE = {~WRH_N,~WRL_N} on writes, 2'b11 on reads.
//   - MEM_DO = DI; DO = read data.
// - BUS16=0 mapping (big-endian):
//   - A[0]=0 selects the high lane, A[0]=1 selects the low lane; MEM_BE = A[0] ? 2'b01 : 2'b10.
//   - MEM_DO = {DI[7:0],DI[7:0]}.
//   - DO = {8'h00, lane byte}; WRH_N is ignored.
// - MEM_WE = ~(WRL_N & WRH_N) at latch time; RD and WR together is illegal and treated as a write.
// - Counters: wait counter 3-bit and timeout counter 8-bit, both saturating, both increment on CE_R in ACC only.
// - ERR: set has priority over ERR_CLR in the same cycle; otherwise ERR_CLR clears ERR.
// - A strobe released while in ACC (master abort): finish the backend handshake, skip HOLD -> IDLE.
// TESTING
// - BUS16=1 read A=24'h000102: MEM_ACK 3 ticks after MEM_REQ, MEM_DI=16'hBEEF -> WAIT_N low 3 ticks, DO=16'hBEEF, DO_OE until RD_N high.
// - WRH_N only, DI=16'h12AB -> MEM_WE=1, MEM_BE=2'b10, MEM_DO=16'h12AB, single MEM_REQ pulse-train ending on ACK.
// - BUS16=0 under held CS_N, reads A=..0 then ..1 with MEM_DI=16'h5A3C -> DO=16'h005A, then DO=16'h003C.
// - Two accesses, two MEM_REQs.
// - No MEM_ACK, TIMEOUT=4 -> WAIT_N released after 4 CE_R ticks, DO=16'hFFFF, ERR=1; ERR_CLR with a new timeout in the same cycle -> ERR stays 1.
// - MIN_WAIT=3 with MEM_ACK the same cycle as MEM_REQ -> WAIT_N low exactly 3 ticks.
// - RST during ACC -> WAIT_N=1, MEM_REQ=0 the next CLK; a late ACK produces no DO_OE.

Source files
------------

// File: rtl/sh7034_ext_slave.sv
`default_nettype none
// ============================================================================
// Module   : sh7034_ext_slave
// Purpose  : SH7034 external-bus device-side responder. Turns CS/RD/WR strobed
//            cycles into a REQ/ACK backend access, stretching with WAIT_N.
// Revision : 1.0  initial release
// ============================================================================
module sh7034_ext_slave #(
    parameter bit          BUS16    = 1'b1,
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [23:0] A,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        DO_OE,
    input  logic        CS_N,
    input  logic        RD_N,
    input  logic        WRL_N,
    input  logic        WRH_N,
    output logic        WAIT_N,
    output logic [23:0] MEM_A,
    output logic [15:0] MEM_DO,
    input  logic [15:0] MEM_DI,
    output logic [1:0]  MEM_BE,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    output logic        ERR,
    input  logic        ERR_CLR
);

    localparam logic [2:0] c_MIN_WAIT = 3'(MIN_WAIT);
    localparam logic [7:0] c_TIMEOUT  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state,  w_state_nxt;
    logic [15:0] r_do,     w_do_nxt;
    logic        r_do_oe,  w_do_oe_nxt;
    logic        r_wait_n, w_wait_n_nxt;
    logic        r_req,    w_req_nxt;
    logic        r_we,     w_we_nxt;
    logic [1:0]  r_be,     w_be_nxt;
    logic [23:0] r_mem_a,  w_mem_a_nxt;
    logic [15:0] r_mem_do, w_mem_do_nxt;
    logic [15:0] r_rdata,  w_rdata_nxt;
    logic        r_done,   w_done_nxt;
    logic [2:0]  r_wcnt,   w_wcnt_nxt;
    logic [7:0]  r_tcnt,   w_tcnt_nxt;
    logic        r_err,    w_err_set;

    logic        w_strobe;
    logic        w_idle_bus;
    logic        w_ack;
    logic        w_done;
    logic        w_ok;
    logic        w_timeout;
    logic        w_wr;
    logic [2:0]  w_wcnt_inc;
    logic [7:0]  w_tcnt_inc;
    logic [15:0] w_rsel;
    logic [15:0] w_lane;
    logic [1:0]  w_be_lat;
    logic [15:0] w_mdo_lat;
    logic        w_unused;

    assign w_unused   = &{1'b0, CE_F};

    assign w_strobe   = ~CS_N & (~RD_N | ~WRL_N | ~WRH_N);
    assign w_idle_bus = RD_N & WRL_N & WRH_N;
    // An ACK is only meaningful while a request is outstanding; this also
    // discards late ACKs after a timeout or reset.
    assign w_ack      = MEM_ACK & r_req;
    assign w_done     = r_done | w_ack;
    assign w_wcnt_inc = (r_wcnt == 3'd7)  ? r_wcnt : r_wcnt + 3'd1;
    assign w_tcnt_inc = (r_tcnt == 8'hFF) ? r_tcnt : r_tcnt + 8'd1;
    assign w_ok       = w_done & (w_wcnt_inc >= c_MIN_WAIT);
    assign w_timeout  = ~w_ok & (w_tcnt_inc >= c_TIMEOUT);
    assign w_rsel     = w_timeout ? 16'hFFFF : (w_ack ? MEM_DI : r_rdata);

    generate
        if (BUS16) begin : g_bus16
            assign w_wr      = ~(WRL_N & WRH_N);
            assign w_be_lat  = w_wr ? {~WRH_N, ~WRL_N} : 2'b11;
            assign w_mdo_lat = DI;
            assign w_lane    = w_rsel;
        end else begin : g_bus8
            // Big-endian byte lanes: even address is the high byte.
            assign w_wr      = ~WRL_N;
            assign w_be_lat  = A[0] ? 2'b01 : 2'b10;
            assign w_mdo_lat = {DI[7:0], DI[7:0]};
            assign w_lane    = {8'h00, (r_mem_a[0] ? w_rsel[7:0] : w_rsel[15:8])};
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_do_nxt     = r_do;
        w_do_oe_nxt  = r_do_oe;
        w_wait_n_nxt = r_wait_n;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_be_nxt     = r_be;
        w_mem_a_nxt  = r_mem_a;
        w_mem_do_nxt = r_mem_do;
        w_rdata_nxt  = r_rdata;
        w_done_nxt   = r_done;
        w_wcnt_nxt   = r_wcnt;
        w_tcnt_nxt   = r_tcnt;
        w_err_set    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (CE_R && w_strobe) begin
                    w_mem_a_nxt  = A;
                    w_mem_do_nxt = w_mdo_lat;
                    w_be_nxt     = w_be_lat;
                    w_we_nxt     = w_wr;
                    w_req_nxt    = 1'b1;
                    w_wait_n_nxt = 1'b0;
                    w_done_nxt   = 1'b0;
                    w_wcnt_nxt   = 3'd0;
                    w_tcnt_nxt   = 8'd0;
                    w_state_nxt  = S_ACC;
                end
            end

            S_ACC: begin
                if (w_ack) begin
                    w_rdata_nxt = MEM_DI;
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end
                if (CE_R) begin
                    w_wcnt_nxt = w_wcnt_inc;
                    w_tcnt_nxt = w_tcnt_inc;
                    if (w_ok || w_timeout) begin
                        w_wait_n_nxt = 1'b1;
                        w_do_nxt     = w_lane;
                        w_rdata_nxt  = w_rsel;
                        if (w_timeout) begin
                            w_req_nxt = 1'b0;
                            w_err_set = 1'b1;
                        end
                        // A master that already dropped its strobe gets no HOLD phase.
                        if (w_strobe) begin
                            w_do_oe_nxt = ~RD_N;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_do_oe_nxt = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (CE_R && w_idle_bus) begin
                    w_do_oe_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_do     <= 16'h0000;
            r_do_oe  <= 1'b0;
            r_wait_n <= 1'b1;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= 2'b00;
            r_mem_a  <= 24'h000000;
            r_mem_do <= 16'h0000;
            r_rdata  <= 16'h0000;
            r_done   <= 1'b0;
            r_wcnt   <= 3'd0;
            r_tcnt   <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_do     <= w_do_nxt;
            r_do_oe  <= w_do_oe_nxt;
            r_wait_n <= w_wait_n_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_be     <= w_be_nxt;
            r_mem_a  <= w_mem_a_nxt;
            r_mem_do <= w_mem_do_nxt;
            r_rdata  <= w_rdata_nxt;
            r_done   <= w_done_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
            // A fresh timeout wins over a simultaneous clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    assign DO      = r_do;
    assign DO_OE   = r_do_oe;
    assign WAIT_N  = r_wait_n;
    assign MEM_A   = r_mem_a;
    assign MEM_DO  = r_mem_do;
    assign MEM_BE  = r_be;
    assign MEM_WE  = r_we;
    assign MEM_REQ = r_req;
    assign ERR     = r_err;

endmodule
`default_nettype wire
